fetch_line_unit: RTL and testbench

Parametrised instruction fetch unit and successor to the single-request fetcher. It holds the fetch PC and refills a one-line instruction buffer over an AXI read burst. It extracts 32-bit instructions into a FIFO fetch queue and supports pipeline redirect with flush and draining of in-flight bursts. It sits between the decode stage (valid/ready consumer) and the AXI instruction memory port.

---
 rtl/fetch_line_unit.sv | 201 ++++++++++++++++++++
 tb/tb_fetch_line_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_line_unit.sv
// Instruction fetch unit: one-line buffer refilled by AXI read bursts, feeding a FWFT
// fetch queue toward decode, with redirect/flush and draining of abandoned bursts.
module fetch_line_unit #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int LINE_BEATS  = 8,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              busy,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic              m_axi_rlast
);
    localparam int LINE_BYTES = LINE_BEATS * 8;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int BI_W       = $clog2(LINE_BEATS);
    localparam int QP_W       = $clog2(QUEUE_DEPTH);
    localparam logic [ADDR_W-1:0] TAG_MASK  = ~ADDR_W'(LINE_BYTES - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_FILL, S_DELIVER, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] line_tag_q, line_tag_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic              line_valid_q, line_valid_d;
    logic              redir_pend_q, redir_pend_d;
    logic [BI_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0] line_buf_q [LINE_BEATS];

    logic [31:0]       q_instr_q [QUEUE_DEPTH];
    logic [ADDR_W-1:0] q_pc_q [QUEUE_DEPTH];
    logic [QP_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [QP_W:0]     count_q;

    logic              line_hit, idle_hit, redir_hit, q_full, beat_acc, last_beat;
    logic              flush, push, pop, buf_we;
    logic [ADDR_W-1:0] idle_pc, redir_pc_m;
    logic [BI_W-1:0]   beat_idx;
    logic [DATA_W-1:0] cur_beat;
    logic [31:0]       cur_instr;

    assign line_hit   = line_valid_q && ((fetch_pc_q & TAG_MASK) == line_tag_q);
    assign idle_pc    = (redirect_valid ? redirect_pc : start_pc) & WORD_MASK;
    assign idle_hit   = line_valid_q && ((idle_pc & TAG_MASK) == line_tag_q);
    assign redir_pc_m = redirect_pc & WORD_MASK;
    assign redir_hit  = line_valid_q && ((redir_pc_m & TAG_MASK) == line_tag_q);
    assign beat_idx   = fetch_pc_q[OFF_W-1:3];
    assign cur_beat   = line_buf_q[beat_idx];
    assign cur_instr  = fetch_pc_q[2] ? cur_beat[63:32] : cur_beat[31:0];
    assign q_full     = (count_q == (QP_W+1)'(QUEUE_DEPTH));
    assign beat_acc   = m_axi_rvalid && m_axi_rready;
    assign last_beat  = m_axi_rlast || (beat_cnt_q == BI_W'(LINE_BEATS - 1));

    assign flush = redirect_valid && (state_q != S_IDLE);
    assign push  = (state_q == S_DELIVER) && line_hit && !q_full && !redirect_valid;
    assign pop   = instr_valid && instr_ready && !flush;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        line_tag_d    = line_tag_q;
        line_valid_d  = line_valid_q;
        redir_pend_d  = redir_pend_q;
        beat_cnt_d    = beat_cnt_q;
        ar_addr_d     = ar_addr_q;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        buf_we        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start || redirect_valid) begin
                    fetch_pc_d = idle_pc;
                    state_d    = idle_hit ? S_DELIVER : S_REQ;
                end
            end
            S_REQ: begin
                m_axi_arvalid = 1'b1;
                if (redirect_valid) begin
                    fetch_pc_d   = redir_pc_m;
                    redir_pend_d = 1'b1;
                end
                if (m_axi_arready) begin
                    // The buffer is about to be overwritten, so the old line stops hitting.
                    line_valid_d = 1'b0;
                    beat_cnt_d   = '0;
                    redir_pend_d = 1'b0;
                    state_d      = (redir_pend_q || redirect_valid) ? S_DRAIN : S_FILL;
                end
            end
            S_FILL: begin
                m_axi_rready = 1'b1;
                if (beat_acc) begin
                    buf_we     = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                if (redirect_valid) begin
                    fetch_pc_d   = redir_pc_m;
                    line_valid_d = 1'b0;
                    // A redirect landing on the final beat has nothing left to drain.
                    state_d      = (beat_acc && last_beat) ? S_REQ : S_DRAIN;
                end else if (beat_acc && last_beat) begin
                    line_valid_d = 1'b1;
                    line_tag_d   = fetch_pc_q & TAG_MASK;
                    state_d      = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc_m;
                    state_d    = redir_hit ? S_DELIVER : S_REQ;
                end else if (!line_hit) begin
                    state_d = S_REQ;
                end else if (push) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                end
            end
            S_DRAIN: begin
                m_axi_rready = 1'b1;
                if (redirect_valid) fetch_pc_d = redir_pc_m;
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_beat) state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_REQ && state_q != S_REQ) ar_addr_d = fetch_pc_d & TAG_MASK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= '0;
            line_tag_q   <= '0;
            line_valid_q <= 1'b0;
            redir_pend_q <= 1'b0;
            beat_cnt_q   <= '0;
            ar_addr_q    <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            line_tag_q   <= line_tag_d;
            line_valid_q <= line_valid_d;
            redir_pend_q <= redir_pend_d;
            beat_cnt_q   <= beat_cnt_d;
            ar_addr_q    <= ar_addr_d;
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage arrays need no reset; validity is tracked by line_valid_q and count_q.
    always_ff @(posedge clk) begin
        if (buf_we) line_buf_q[beat_cnt_q] <= m_axi_rdata;
        if (push) begin
            q_instr_q[wr_ptr_q] <= cur_instr;
            q_pc_q[wr_ptr_q]    <= fetch_pc_q;
        end
    end

    assign instr_valid  = (count_q != '0);
    assign instr_out    = instr_valid ? q_instr_q[rd_ptr_q] : '0;
    assign instr_pc     = instr_valid ? q_pc_q[rd_ptr_q] : '0;
    assign busy         = (state_q != S_IDLE);
    assign m_axi_araddr = ar_addr_q;
    assign m_axi_arlen  = 8'(LINE_BEATS - 1);
    assign m_axi_arsize = 3'd3;

endmodule

// File: tb/tb_fetch_line_unit.sv
// Bench for fetch_line_unit: AXI memory model, stream reference model of the expected
// instruction sequence, directed scenarios and a randomized redirect/stall phase.
module tb_fetch_line_unit;
    logic        clk = 1'b0;
    logic        reset, start, redirect_valid, instr_ready;
    logic [63:0] start_pc, redirect_pc;
    logic        instr_valid, busy;
    logic [31:0] instr_out;
    logic [63:0] instr_pc;
    logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast;
    logic [63:0] m_axi_araddr, m_axi_rdata;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;

    fetch_line_unit dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
        .instr_pc(instr_pc), .busy(busy),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [31:0] word(logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] beat_data(logic [63:0] a);
        return {word(a + 64'd4), word(a)};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // AXI memory model: drives at the falling edge, accounts handshakes one edge later.
    bit          slv_det  = 1'b1;
    bit          ar_stall = 1'b0;
    logic [63:0] bq[$];
    logic [63:0] ar_log[$];
    int          beat = 0;
    bit          ar_pend = 1'b0, r_pend = 1'b0;
    logic [63:0] ar_pend_addr;

    initial begin
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rlast   = 1'b0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                bq.delete();
                beat = 0; ar_pend = 1'b0; r_pend = 1'b0;
                m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
            end else begin
                if (ar_pend) begin
                    bq.push_back(ar_pend_addr);
                    ar_log.push_back(ar_pend_addr);
                end
                if (r_pend) begin
                    beat++;
                    if (beat == 8) begin
                        beat = 0;
                        void'(bq.pop_front());
                    end
                end
                m_axi_arready = !ar_stall && (slv_det || $urandom_range(0, 1) == 1);
                ar_pend       = m_axi_arvalid && m_axi_arready;
                ar_pend_addr  = m_axi_araddr;
                if (bq.size() > 0) begin
                    m_axi_rvalid = slv_det || $urandom_range(0, 3) != 0;
                    m_axi_rdata  = beat_data(bq[0] + 64'(8 * beat));
                    m_axi_rlast  = (beat == 7);
                end else begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                end
                r_pend = m_axi_rvalid && m_axi_rready;
            end
        end
    end

    // Reference model: after start/redirect the stream is pc, pc+4, ... with pc word aligned.
    logic [63:0] exp_pc = '0;
    bit          exp_ok = 1'b0;
    int          n_pop  = 0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset !== 1'b0) begin
                exp_ok = 1'b0;
            end else if (!busy) begin
                if (redirect_valid) begin
                    exp_pc = redirect_pc & ~64'h3; exp_ok = 1'b1;
                end else if (start) begin
                    exp_pc = start_pc & ~64'h3; exp_ok = 1'b1;
                end
            end else if (redirect_valid) begin
                exp_pc = redirect_pc & ~64'h3;
            end else if (instr_valid && instr_ready) begin
                chk("pop_expected", 64'(exp_ok), 64'd1);
                chk("pop_pc", instr_pc, exp_pc);
                chk("pop_instr", 64'(instr_out), 64'(word(exp_pc)));
                exp_pc = exp_pc + 64'd4;
                n_pop++;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        repeat (2) tick();
        ar_log.delete();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_valid(string tag, int budget);
        int t = 0;
        while (!instr_valid && t < budget) begin tick(); t++; end
        chk(tag, 64'(instr_valid), 64'd1);
    endtask

    initial begin
        int cyc, t, nar, pops0;
        reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        start_pc = '0; redirect_pc = '0;
        repeat (3) tick();
        chk("rst_instr_valid", 64'(instr_valid), 0);
        chk("rst_instr_out", 64'(instr_out), 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_arvalid", 64'(m_axi_arvalid), 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_rready", 64'(m_axi_rready), 0);
        chk("rst_arlen", 64'(m_axi_arlen), 7);
        chk("rst_arsize", 64'(m_axi_arsize), 3);

        // Basic fill, latency, stall on full queue, streaming, next-line request.
        do_reset();
        start = 1'b1; start_pc = 64'h1000;
        tick();
        start = 1'b0;
        chk("a_arvalid", 64'(m_axi_arvalid), 1);
        chk("a_araddr", m_axi_araddr, 64'h1000);
        chk("a_arlen", 64'(m_axi_arlen), 7);
        chk("a_busy", 64'(busy), 1);
        cyc = 1;
        while (!instr_valid && cyc < 60) begin tick(); cyc++; end
        chk("a_valid_latency", 64'(cyc), 64'd11);
        chk("a_first_pc", instr_pc, 64'h1000);
        chk("a_first_instr", 64'(instr_out), 64'(word(64'h1000)));
        repeat (12) tick();
        chk("a_stalled_head", instr_pc, 64'h1000);
        instr_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("a_stream_valid", 64'(instr_valid), 1);
            tick();
        end
        t = 0;
        while (ar_log.size() < 2 && t < 40) begin tick(); t++; end
        chk("a_ar_count", 64'(ar_log.size()), 2);
        if (ar_log.size() >= 2) chk("a_next_line", ar_log[1], 64'h1040);
        repeat (30) tick();

        // Redirect within the buffered line, simultaneous with a pop.
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1; start_pc = 64'h1000;
        tick();
        start = 1'b0;
        t = 0;
        while (!(instr_valid && instr_pc == 64'h1008) && t < 60) begin tick(); t++; end
        chk("b_reach_1008", instr_pc, 64'h1008);
        nar = ar_log.size();
        redirect_valid = 1'b1; redirect_pc = 64'h1020;
        tick();
        redirect_valid = 1'b0;
        chk("b_flushed", 64'(instr_valid), 0);
        tick();
        chk("b_valid_2cyc", 64'(instr_valid), 1);
        chk("b_redir_pc", instr_pc, 64'h1020);
        repeat (3) tick();
        chk("b_no_ar", 64'(ar_log.size()), 64'(nar));

        // Redirect during beat 3 of a fill: drain, then refetch target line.
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1; start_pc = 64'h1000;
        tick();
        start = 1'b0;
        t = 0;
        while (!(m_axi_rvalid && m_axi_rready && beat == 3) && t < 30) begin tick(); t++; end
        chk("c_beat3", 64'(beat), 3);
        redirect_valid = 1'b1; redirect_pc = 64'h2008;
        tick();
        redirect_valid = 1'b0;
        t = 0;
        while (!m_axi_arvalid && t < 30) begin
            chk("c_drain_rready", 64'(m_axi_rready), 1);
            chk("c_drain_nopush", 64'(instr_valid), 0);
            tick(); t++;
        end
        chk("c_req_araddr", m_axi_araddr, 64'h2000);
        wait_valid("c_valid_timeout", 40);
        chk("c_first_pc", instr_pc, 64'h2008);

        // Redirect while AR is stalled.
        do_reset();
        ar_stall = 1'b1;
        instr_ready = 1'b1;
        start = 1'b1; start_pc = 64'h1000;
        tick();
        start = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 64'h3010;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("d_ar_hold", 64'(m_axi_arvalid), 1);
            chk("d_araddr_hold", m_axi_araddr, 64'h1000);
            tick();
        end
        ar_stall = 1'b0;
        t = 0;
        while (ar_log.size() < 2 && t < 60) begin
            chk("d_drain_nopush", 64'(instr_valid), 0);
            tick(); t++;
        end
        chk("d_ar_count", 64'(ar_log.size()), 2);
        if (ar_log.size() >= 2) begin
            chk("d_ar0", ar_log[0], 64'h1000);
            chk("d_ar1", ar_log[1], 64'h3000);
        end
        wait_valid("d_valid_timeout", 40);
        chk("d_first_pc", instr_pc, 64'h3010);

        // Start and redirect together in IDLE: redirect wins.
        do_reset();
        start = 1'b1; start_pc = 64'h1000;
        redirect_valid = 1'b1; redirect_pc = 64'h5004;
        tick();
        start = 1'b0; redirect_valid = 1'b0;
        chk("f_araddr", m_axi_araddr, 64'h5000);
        wait_valid("f_valid_timeout", 40);
        chk("f_first_pc", instr_pc, 64'h5004);

        // Unaligned start, then random stalls, consumer backpressure and redirects.
        do_reset();
        slv_det = 1'b0;
        start = 1'b1; start_pc = 64'h1003;
        tick();
        start = 1'b0;
        wait_valid("e_valid_timeout", 80);
        chk("e_first_pc", instr_pc, 64'h1000);
        pops0 = n_pop;
        for (int i = 0; i < 3000; i++) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 99) == 0);
            redirect_pc    = 64'h4000 + 64'($urandom_range(0, 255));
            tick();
        end
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        chk("e_progress", 64'(n_pop - pops0 > 200), 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
